// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: parity modes, FSM states, bit-period helper.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   // Clock cycles per bit, rounded to nearest.
   function automatic int uart_div(input int clk_freq, input int baud);
      return int'((longint'(clk_freq) + longint'(baud / 2)) / longint'(baud));
   endfunction

endpackage

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with show-ahead read data; pointers carry an extra MSB to tell full from empty.
module sync_fifo_param #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sync_fifo_param: DEPTH must be a power of two >= 2");
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             push;
   logic             pop;

   assign level    = wr_ptr - rd_ptr;
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign push     = wr_en && !full;
   assign pop      = rd_en && !empty;
   // Rejected writes flag in the same cycle, regardless of a concurrent pop.
   assign overflow = wr_en && full;
   assign rd_data  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Buffered UART transmitter: FIFO feeds a start/data/parity/stop framer, frames sent back-to-back.
module uart_tx_fifo_param
   import uart_pkg::*;
#(
   parameter int clk_freq       = 100000000,
   parameter int uart_baud_rate = 115200,
   parameter int DATA_BITS      = 8,
   parameter int PARITY         = 0,
   parameter int STOP_BITS      = 1,
   parameter int FIFO_DEPTH     = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_en,
   input  logic [DATA_BITS-1:0]          wr_data,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          overflow,
   output logic                          busy,
   output logic                          uart_txd
);

   if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
       PARITY < 0 || PARITY > 2) begin : g_bad_param
      $error("uart_tx_fifo_param: illegal DATA_BITS/PARITY/STOP_BITS");
   end

   localparam int DIV = uart_div(clk_freq, uart_baud_rate);
   localparam int CW  = $clog2(DIV + 1);
   localparam int BCW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0]  DIV_LAST  = CW'(DIV - 1);
   localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BITS - 1);
   localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);

   uart_state_t          state, state_n;
   logic [CW-1:0]        cnt, cnt_n;
   logic [BCW-1:0]       bit_cnt, bit_cnt_n;
   logic [DATA_BITS-1:0] shreg, shreg_n;
   logic                 par_bit, par_n;
   logic                 txd_n;
   logic                 pop;
   logic                 bit_end;
   logic [DATA_BITS-1:0] fifo_head;

   sync_fifo_param #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .rd_en    (pop),
      .rd_data  (fifo_head),
      .full     (full),
      .empty    (empty),
      .level    (level),
      .overflow (overflow)
   );

   assign busy    = (state != ST_IDLE);
   assign bit_end = (cnt == DIV_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         bit_cnt  <= '0;
         uart_txd <= 1'b1;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         bit_cnt  <= bit_cnt_n;
         uart_txd <= txd_n;
      end
   end

   always_ff @(posedge clk) begin
      shreg   <= shreg_n;
      par_bit <= par_n;
   end

   always_comb begin
      state_n   = state;
      cnt_n     = bit_end ? '0 : cnt + 1'b1;
      bit_cnt_n = bit_cnt;
      shreg_n   = shreg;
      par_n     = par_bit;
      txd_n     = uart_txd;
      pop       = 1'b0;
      case (state)
         ST_IDLE: begin
            cnt_n = '0;
            txd_n = 1'b1;
            if (!empty) begin
               pop       = 1'b1;
               shreg_n   = fifo_head;
               par_n     = (^fifo_head) ^ (PARITY == PAR_ODD);
               bit_cnt_n = '0;
               state_n   = ST_START;
               txd_n     = 1'b0;
            end
         end
         ST_START: begin
            if (bit_end) begin
               state_n   = ST_DATA;
               bit_cnt_n = '0;
               txd_n     = shreg[0];
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               if (bit_cnt == DATA_LAST) begin
                  bit_cnt_n = '0;
                  if (PARITY != PAR_NONE) begin
                     state_n = ST_PARITY;
                     txd_n   = par_bit;
                  end else begin
                     state_n = ST_STOP;
                     txd_n   = 1'b1;
                  end
               end else begin
                  bit_cnt_n = bit_cnt + 1'b1;
                  shreg_n   = {1'b0, shreg[DATA_BITS-1:1]};
                  txd_n     = shreg[1];
               end
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               state_n   = ST_STOP;
               bit_cnt_n = '0;
               txd_n     = 1'b1;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               if (bit_cnt != STOP_LAST) begin
                  bit_cnt_n = bit_cnt + 1'b1;
               end else if (!empty) begin
                  // Chain straight into the next start bit with no idle gap.
                  pop       = 1'b1;
                  shreg_n   = fifo_head;
                  par_n     = (^fifo_head) ^ (PARITY == PAR_ODD);
                  bit_cnt_n = '0;
                  state_n   = ST_START;
                  txd_n     = 1'b0;
               end else begin
                  state_n = ST_IDLE;
                  txd_n   = 1'b1;
               end
            end
         end
         default: begin
            state_n = ST_IDLE;
            txd_n   = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Random-plus-directed bench for uart_tx_fifo_param over four frame formats, checked cycle by cycle
// against a frame-timeline reference model.
module tb_uart_tx_fifo_param;

   localparam int DIV = 87;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] wr_en_v;
   logic [8:0] wr_data_a [4];
   logic [3:0] txd_v, busy_v, full_v, empty_v, ovf_v;
   logic [5:0] level_a [4];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // f: 0 data bits, 1 parity, 2 stop bits, 3 fifo depth
   function automatic int cfg(input int i, input int f);
      case (i)
         0:       case (f) 0: return 8; 1: return 0; 2: return 1; default: return 16; endcase
         1:       case (f) 0: return 8; 1: return 2; 2: return 1; default: return 4;  endcase
         2:       case (f) 0: return 8; 1: return 1; 2: return 1; default: return 8;  endcase
         default: case (f) 0: return 7; 1: return 0; 2: return 2; default: return 2;  endcase
      endcase
   endfunction

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int DB   = cfg(g, 0);
      localparam int PAR  = cfg(g, 1);
      localparam int SB   = cfg(g, 2);
      localparam int DEP  = cfg(g, 3);
      localparam int FLEN = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;

      logic [$clog2(DEP):0] lvl;
      logic full_s, empty_s, ovf_s, busy_s, txd_s;

      uart_tx_fifo_param #(
         .clk_freq       (100000000),
         .uart_baud_rate (1152000),
         .DATA_BITS      (DB),
         .PARITY         (PAR),
         .STOP_BITS      (SB),
         .FIFO_DEPTH     (DEP)
      ) u_dut (
         .clk      (clk),
         .rst      (rst),
         .wr_en    (wr_en_v[g]),
         .wr_data  (wr_data_a[g][DB-1:0]),
         .full     (full_s),
         .empty    (empty_s),
         .level    (lvl),
         .overflow (ovf_s),
         .busy     (busy_s),
         .uart_txd (txd_s)
      );

      assign txd_v[g]   = txd_s;
      assign busy_v[g]  = busy_s;
      assign full_v[g]  = full_s;
      assign empty_v[g] = empty_s;
      assign ovf_v[g]   = ovf_s;
      assign level_a[g] = 6'(lvl);

      int q[$];
      int cur = 0;
      int t = 0;
      bit active = 1'b0;

      // Line level for bit slot k of the current frame.
      function automatic int exp_bit(input int k);
         int ones;
         if (k == 0) return 0;
         if (k <= DB) return (cur >> (k - 1)) & 1;
         if (PAR != 0 && k == DB + 1) begin
            ones = $countones(cur);
            return (PAR == 2) ? (ones % 2) : (1 - (ones % 2));
         end
         return 1;
      endfunction

      always @(posedge clk) begin
         bit full_pre, ne_pre;
         if (!rst) begin
            q.delete();
            active = 1'b0;
            t = 0;
         end else begin
            chk($sformatf("ovf%0d", g), ovf_s, (wr_en_v[g] && q.size() == DEP) ? 1 : 0);
            full_pre = (q.size() == DEP);
            ne_pre   = (q.size() != 0);
            if (active) begin
               t++;
               if (t == FLEN * DIV) active = 1'b0;
            end
            if (!active && ne_pre) begin
               cur = q.pop_front();
               active = 1'b1;
               t = 0;
            end
            if (wr_en_v[g] && !full_pre) q.push_back(int'(wr_data_a[g][DB-1:0]));
         end
         #1;
         chk($sformatf("txd%0d", g),   txd_s,   active ? exp_bit(t / DIV) : 1);
         chk($sformatf("busy%0d", g),  busy_s,  active ? 1 : 0);
         chk($sformatf("level%0d", g), lvl,     q.size());
         chk($sformatf("full%0d", g),  full_s,  (q.size() == DEP) ? 1 : 0);
         chk($sformatf("empty%0d", g), empty_s, (q.size() == 0) ? 1 : 0);
      end
   end

   task automatic drain(input int lim);
      bit done;
      done = 1'b0;
      for (int i = 0; i < lim && !done; i++) begin
         @(negedge clk);
         if (busy_v == 4'h0 && empty_v == 4'hF) done = 1'b1;
      end
      chk("drain", done, 1);
   endtask

   initial begin
      int c0, c1, c3, lows;
      rst = 1'b0;
      wr_en_v = 4'h0;
      for (int i = 0; i < 4; i++) wr_data_a[i] = '0;

      repeat (4) begin
         @(negedge clk);
         chk("rst_txd",   txd_v,   4'hF);
         chk("rst_busy",  busy_v,  4'h0);
         chk("rst_empty", empty_v, 4'hF);
         chk("rst_full",  full_v,  4'h0);
         chk("rst_ovf",   ovf_v,   4'h0);
         chk("rst_level", level_a[0], 0);
      end
      rst = 1'b1;

      // One directed character per format.
      @(negedge clk);
      wr_data_a[0] = 9'h055;
      wr_data_a[1] = 9'h007;
      wr_data_a[2] = 9'h007;
      wr_data_a[3] = 9'h07F;
      wr_en_v = 4'hF;
      @(negedge clk);
      wr_en_v = 4'h0;
      c0 = 0; c1 = 0; c3 = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (busy_v[0]) c0++;
         if (busy_v[1]) c1++;
         if (busy_v[3]) c3++;
      end
      chk("busy_len_8n1", c0, 870);
      chk("busy_len_8e1", c1, 957);
      chk("busy_len_7n2", c3, 870);

      // Burst of 18 consecutive writes.
      for (int i = 0; i < 18; i++) begin
         for (int g = 0; g < 4; g++) wr_data_a[g] = 9'($urandom);
         wr_en_v = 4'hF;
         @(negedge clk);
      end
      wr_en_v = 4'h0;
      drain(20000);

      // Sparse random writes, enough to overrun the shallow FIFOs.
      for (int i = 0; i < 6000; i++) begin
         for (int g = 0; g < 4; g++) begin
            wr_en_v[g]   = ($urandom_range(0, 149) == 0);
            wr_data_a[g] = 9'($urandom);
         end
         @(negedge clk);
      end
      wr_en_v = 4'h0;
      drain(20000);

      // Reset in the middle of data bit 3.
      for (int i = 0; i < 3; i++) begin
         for (int g = 0; g < 4; g++) wr_data_a[g] = 9'($urandom);
         wr_en_v = 4'hF;
         @(negedge clk);
      end
      wr_en_v = 4'h0;
      repeat (4 * DIV + 20) @(negedge clk);
      chk("pre_rst_busy", busy_v[0], 1);
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("midrst_txd",   txd_v,      4'hF);
      chk("midrst_level", level_a[0], 0);
      chk("midrst_busy",  busy_v,     4'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      lows = 0;
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         if (txd_v != 4'hF) lows++;
      end
      chk("idle_after_rst", lows, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
